// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver/consumer side and uart_rx_fifo.
// The master modport drives push/pop/clear; the slave modport is the FIFO itself.
interface uart_rx_fifo_if #(
   parameter int unsigned AW = 4
);
   logic          wr_valid;
   logic [7:0]    wr_data;
   logic          rd_en;
   logic          clr_ovf;
   logic          rd_valid;
   logic [7:0]    rd_data;
   logic [AW:0]   count;
   logic          full;
   logic          overflow;

   modport master (
      output wr_valid,
      output wr_data,
      output rd_en,
      output clr_ovf,
      input  rd_valid,
      input  rd_data,
      input  count,
      input  full,
      input  overflow
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      input  rd_en,
      input  clr_ovf,
      output rd_valid,
      output rd_data,
      output count,
      output full,
      output overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with sticky overflow.
// Define UART_FIFO_DROP_OLDEST_EN to overwrite the oldest entry on overflow instead of dropping.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   uart_rx_fifo_if.slave bus
);

   localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CntOne   = (AW+1)'(1);
   localparam logic [AW-1:0] PtrOne   = AW'(1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;

   logic is_full;
   logic is_empty;
   logic pop;
   logic push;
   logic lost;
   logic mem_we;
   logic rd_adv;

   always_comb begin
      is_full  = (count_q == DepthCnt);
      is_empty = (count_q == '0);
      pop      = bus.rd_en && !is_empty;
      // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
      push     = bus.wr_valid && (!is_full || pop);
      lost     = bus.wr_valid && is_full && !pop;
`ifdef UART_FIFO_DROP_OLDEST_EN
      mem_we   = push || lost;
      rd_adv   = pop || lost;
`else
      mem_we   = push;
      rd_adv   = pop;
`endif
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (mem_we) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_adv) rd_ptr_d = rd_ptr_q + PtrOne;

      case ({push, pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase

      if (lost) begin
         ovf_d = 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage carries no reset; rd_valid qualifies rd_data.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   always_comb begin
      bus.rd_data  = mem_q[rd_ptr_q];
      bus.rd_valid = !is_empty;
      bus.count    = count_q;
      bus.full     = is_full;
      bus.overflow = ovf_q;
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic clk;
   logic rst_n;

   uart_rx_fifo_if #(.AW(AW)) bus ();

   uart_rx_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of bytes plus a sticky flag.
   logic [7:0] mq[$];
   logic       m_ovf;

   initial begin
      mq.delete();
      m_ovf = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
         end else begin
            automatic bit was_full = (mq.size() == DEPTH);
            automatic bit popped   = 1'b0;
            automatic bit lostw    = 1'b0;
            if (bus.rd_en && mq.size() > 0) begin
               void'(mq.pop_front());
               popped = 1'b1;
            end
            if (bus.wr_valid) begin
               if (mq.size() < DEPTH) begin
                  mq.push_back(bus.wr_data);
               end else begin
                  lostw = 1'b1;
`ifdef UART_FIFO_DROP_OLDEST_EN
                  void'(mq.pop_front());
                  mq.push_back(bus.wr_data);
`endif
               end
            end
            if (lostw && was_full && !popped) m_ovf = 1'b1;
            else if (bus.clr_ovf)             m_ovf = 1'b0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("m_count", 32'(bus.count), 32'(mq.size()));
         chk("m_rd_valid", 32'(bus.rd_valid), 32'(mq.size() != 0));
         chk("m_full", 32'(bus.full), 32'(mq.size() == DEPTH));
         chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
         if (mq.size() != 0) chk("m_rd_data", 32'(bus.rd_data), 32'(mq[0]));
      end
   end

   // One cycle of stimulus; entered and left at 2 time units after a rising edge.
   task automatic step(input logic wv, input logic [7:0] wd, input logic re, input logic clr);
      bus.wr_valid = wv;
      bus.wr_data  = wd;
      bus.rd_en    = re;
      bus.clr_ovf  = clr;
      @(posedge clk);
      #2;
      bus.wr_valid = 1'b0;
      bus.rd_en    = 1'b0;
      bus.clr_ovf  = 1'b0;
   endtask

   task automatic pop_exp(input logic [7:0] exp);
      chk("pop_valid", 32'(bus.rd_valid), 32'd1);
      chk("pop_data", 32'(bus.rd_data), 32'(exp));
      step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_data  = 8'h00;
      bus.rd_en    = 1'b0;
      bus.clr_ovf  = 1'b0;
      rst_n        = 1'b0;
      #1;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Three bytes in, three out.
      step(1'b1, 8'h41, 1'b0, 1'b0);
      chk("first_latency_valid", 32'(bus.rd_valid), 32'd1);
      step(1'b1, 8'h42, 1'b0, 1'b0);
      step(1'b1, 8'h43, 1'b0, 1'b0);
      chk("abc_count", 32'(bus.count), 32'd3);
      chk("abc_head", 32'(bus.rd_data), 32'h41);
      pop_exp(8'h41);
      pop_exp(8'h42);
      pop_exp(8'h43);
      chk("abc_empty_valid", 32'(bus.rd_valid), 32'd0);
      chk("abc_empty_count", 32'(bus.count), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pop_empty_ignored", 32'(bus.count), 32'd0);

      // Fill, then overflow.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_full", 32'(bus.full), 32'd1);
      chk("fill_no_ovf", 32'(bus.overflow), 32'd0);
      step(1'b1, 8'h10, 1'b0, 1'b0);
      chk("ovf_set", 32'(bus.overflow), 32'd1);
      chk("ovf_count", 32'(bus.count), 32'd16);
      for (int i = 0; i < 16; i++) begin
`ifdef UART_FIFO_DROP_OLDEST_EN
         pop_exp(8'(i + 1));
`else
         pop_exp(8'(i));
`endif
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_cleared", 32'(bus.overflow), 32'd0);

      // Simultaneous push and pop while full.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("pp_head_before", 32'(bus.rd_data), 32'h00);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      chk("pp_count", 32'(bus.count), 32'd16);
      chk("pp_no_ovf", 32'(bus.overflow), 32'd0);
      chk("pp_head_after", 32'(bus.rd_data), 32'h01);
      for (int i = 1; i < 16; i++) pop_exp(8'(i));
      pop_exp(8'h55);
      chk("pp_drained", 32'(bus.count), 32'd0);

      // Simultaneous push and pop while empty: only the push lands.
      step(1'b1, 8'h66, 1'b1, 1'b0);
      chk("pp_empty_count", 32'(bus.count), 32'd1);
      pop_exp(8'h66);

      // Wrap-around at steady occupancy of two.
      step(1'b1, 8'hA0, 1'b0, 1'b0);
      step(1'b1, 8'hA1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         chk("wrap_data", 32'(bus.rd_data), 32'(8'hA0 + 8'(i)));
         step(1'b1, 8'hA2 + 8'(i), 1'b1, 1'b0);
      end
      chk("wrap_count", 32'(bus.count), 32'd2);
      chk("wrap_no_ovf", 32'(bus.overflow), 32'd0);
      pop_exp(8'hC8);
      pop_exp(8'hC9);

      // Set beats clear; clear alone then works; async reset mid-stream.
      for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b0);
      chk("ovf2_set", 32'(bus.overflow), 32'd1);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      chk("set_beats_clr", 32'(bus.overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_alone", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_count", 32'(bus.count), 32'd5);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", 32'(bus.count), 32'd0);
      chk("async_rst_valid", 32'(bus.rd_valid), 32'd0);
      chk("async_rst_full", 32'(bus.full), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("post_rst_count", 32'(bus.count), 32'd1);
      pop_exp(8'h5A);
      @(posedge clk);
      #2;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
